// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy scene renderer: pipe element types,
// palette constants and the colour priority helper.
package flappy_pkg;

  localparam int PIPE_COUNT_DEF = 4;
  localparam int PIPE_X_W       = 12;
  localparam int GAP_Y_W        = 10;

  typedef logic signed [PIPE_X_W-1:0] pipe_x_t;
  typedef logic        [GAP_Y_W-1:0]  gap_y_t;

  localparam logic [23:0] COLOR_BIRD   = 24'hF8D820;
  localparam logic [23:0] COLOR_PIPE   = 24'h5EBF2E;
  localparam logic [23:0] COLOR_GROUND = 24'hDED895;
  localparam logic [23:0] COLOR_SKY    = 24'h70C5CE;

  // Bird over pipe over ground over sky; blanking forces black.
  function automatic logic [23:0] scene_colour(input logic de,
                                               input logic bird_hit,
                                               input logic pipe_hit,
                                               input logic ground_hit);
    logic [23:0] c;
    c = COLOR_SKY;
    if (bird_hit)        c = COLOR_BIRD;
    else if (pipe_hit)   c = COLOR_PIPE;
    else if (ground_hit) c = COLOR_GROUND;
    if (!de) c = 24'h000000;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hit_test.sv
// Combinational hit test for one pipe column: inside the pipe's horizontal
// span and outside its vertical gap.
module pipe_hit_test
  import flappy_pkg::*;
#(
  parameter int X_WIDTH    = 11,
  parameter int Y_WIDTH    = 10,
  parameter int PIPE_WIDTH = 96,
  parameter int GAP_HEIGHT = 192
) (
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  pipe_x_t            pipe_x,
  input  gap_y_t             gap_y,
  output logic               hit
);

  localparam int XE = PIPE_X_W + 1;
  localparam int YE = Y_WIDTH + 1;

  logic signed [XE-1:0] x_s;
  logic signed [XE-1:0] left_s;
  logic signed [XE-1:0] right_s;
  logic [YE-1:0] y_e;
  logic [YE-1:0] gap_top;
  logic [YE-1:0] gap_bot;

  // One extra bit on both axes keeps negative left edges and gap bottoms
  // past the last row from wrapping.
  always_comb begin
    x_s     = XE'($signed({1'b0, x}));
    left_s  = XE'(pipe_x);
    right_s = left_s + XE'(PIPE_WIDTH);
    y_e     = YE'(y);
    gap_top = YE'(gap_y);
    gap_bot = gap_top + YE'(GAP_HEIGHT);
    hit     = (x_s >= left_s) && (x_s < right_s) &&
              ((y_e < gap_top) || (y_e >= gap_bot));
  end

endmodule

// File: rtl/scene_renderer.sv
// Two-stage pixel colour pipeline for the flappy scene: frame-latched scene
// shadows, hit tests, colour selection and a per-frame collision flag.
module scene_renderer
  import flappy_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 1280,
  parameter int VER_ACTIVE_PIXELS = 720,
  parameter int PIPE_COUNT        = PIPE_COUNT_DEF,
  parameter int BIRD_X            = 200,
  parameter int BIRD_SIZE         = 32,
  parameter int PIPE_WIDTH        = 96,
  parameter int GAP_HEIGHT        = 192,
  parameter int GROUND_Y          = 656,
  localparam int X_WIDTH          = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH          = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic                       clk_rgb,
  input  logic                       rst_n,
  input  logic [X_WIDTH-1:0]         x,
  input  logic [Y_WIDTH-1:0]         y,
  input  logic                       hs,
  input  logic                       vs,
  input  logic                       de,
  input  logic [Y_WIDTH-1:0]         bird_y,
  input  pipe_x_t [PIPE_COUNT-1:0]   pipe_x,
  input  gap_y_t  [PIPE_COUNT-1:0]   pipe_gap_y,
  input  logic                       scene_valid,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b,
  output logic                       hs_o,
  output logic                       vs_o,
  output logic                       de_o,
  output logic                       frame_start,
  output logic                       collision
);

  localparam int YE = Y_WIDTH + 1;

  logic                     vs_prev;
  logic                     vs_rise;
  logic [Y_WIDTH-1:0]       sh_bird_y;
  pipe_x_t [PIPE_COUNT-1:0] sh_pipe_x;
  gap_y_t  [PIPE_COUNT-1:0] sh_gap_y;

  logic [PIPE_COUNT-1:0]    pipe_hits;
  logic                     bird_hit_c;
  logic                     pipe_hit_c;
  logic                     ground_hit_c;

  logic                     s1_bird;
  logic                     s1_pipe;
  logic                     s1_ground;
  logic                     s1_hs;
  logic                     s1_vs;
  logic                     s1_de;
  logic                     hit_set;
  logic                     coll_acc;
  logic [23:0]              pix_colour;

  // Gated by rst_n so a shadow load is only ever advertised when it can happen.
  assign vs_rise     = vs & ~vs_prev & rst_n;
  assign frame_start = vs_rise;

  // Scene shadows: live inputs are sampled only at a frame boundary.
  always_ff @(posedge clk_rgb) begin
    if (!rst_n) begin
      vs_prev   <= 1'b1;
      sh_bird_y <= Y_WIDTH'(VER_ACTIVE_PIXELS / 2);
      for (int i = 0; i < PIPE_COUNT; i++) begin
        sh_pipe_x[i] <= pipe_x_t'(HOR_ACTIVE_PIXELS);
        sh_gap_y[i]  <= gap_y_t'((VER_ACTIVE_PIXELS - GAP_HEIGHT) / 2);
      end
    end else begin
      vs_prev <= vs;
      if (vs_rise && scene_valid) begin
        sh_bird_y <= bird_y;
        sh_pipe_x <= pipe_x;
        sh_gap_y  <= pipe_gap_y;
      end
    end
  end

  for (genvar i = 0; i < PIPE_COUNT; i++) begin : g_pipe
    pipe_hit_test #(
      .X_WIDTH    (X_WIDTH),
      .Y_WIDTH    (Y_WIDTH),
      .PIPE_WIDTH (PIPE_WIDTH),
      .GAP_HEIGHT (GAP_HEIGHT)
    ) u_hit (
      .x      (x),
      .y      (y),
      .pipe_x (sh_pipe_x[i]),
      .gap_y  (sh_gap_y[i]),
      .hit    (pipe_hits[i])
    );
  end

  always_comb begin
    bird_hit_c   = (x >= X_WIDTH'(BIRD_X)) &&
                   (x < X_WIDTH'(BIRD_X + BIRD_SIZE)) &&
                   (YE'(y) >= YE'(sh_bird_y)) &&
                   (YE'(y) < YE'(sh_bird_y) + YE'(BIRD_SIZE));
    pipe_hit_c   = |pipe_hits;
    ground_hit_c = (y >= Y_WIDTH'(GROUND_Y));
  end

  // Stage 1: hit tests and syncs.
  always_ff @(posedge clk_rgb) begin
    if (!rst_n) begin
      s1_bird   <= 1'b0;
      s1_pipe   <= 1'b0;
      s1_ground <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_de     <= 1'b0;
    end else begin
      s1_bird   <= bird_hit_c;
      s1_pipe   <= pipe_hit_c;
      s1_ground <= ground_hit_c;
      s1_hs     <= hs;
      s1_vs     <= vs;
      s1_de     <= de;
    end
  end

  assign pix_colour = scene_colour(s1_de, s1_bird, s1_pipe, s1_ground);

  // Stage 2: colour and syncs.
  always_ff @(posedge clk_rgb) begin
    if (!rst_n) begin
      r    <= 8'h00;
      g    <= 8'h00;
      b    <= 8'h00;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
      de_o <= 1'b0;
    end else begin
      r    <= pix_colour[23:16];
      g    <= pix_colour[15:8];
      b    <= pix_colour[7:0];
      hs_o <= s1_hs;
      vs_o <= s1_vs;
      de_o <= s1_de;
    end
  end

  assign hit_set = s1_de & s1_bird & (s1_pipe | s1_ground);

  // A hit landing on the boundary cycle belongs to the frame that is starting.
  always_ff @(posedge clk_rgb) begin
    if (!rst_n) begin
      coll_acc  <= 1'b0;
      collision <= 1'b0;
    end else if (vs_rise) begin
      collision <= coll_acc;
      coll_acc  <= hit_set;
    end else begin
      coll_acc  <= coll_acc | hit_set;
    end
  end

endmodule

// File: tb/tb_scene_renderer.sv
// Bench for scene_renderer: vector tables per scene, a pixel scoreboard
// aligned to the two-cycle latency, and hand sequences for frame behaviour.
module tb_scene_renderer;
  import flappy_pkg::*;

  localparam logic [23:0] SKY    = 24'h70C5CE;
  localparam logic [23:0] BIRD   = 24'hF8D820;
  localparam logic [23:0] PIPE   = 24'h5EBF2E;
  localparam logic [23:0] GROUND = 24'hDED895;

  typedef struct {
    int          s;
    int          x;
    int          y;
    logic        hs;
    logic        de;
    logic [23:0] rgb;
  } vec_t;

  typedef struct {
    int bird;
    int px0;
    int g0;
    int px1;
    int g1;
  } scene_t;

  logic              clk_rgb = 1'b0;
  logic              rst_n = 1'b0;
  logic [10:0]       x = '0;
  logic [9:0]        y = '0;
  logic              hs = 1'b0;
  logic              vs = 1'b0;
  logic              de = 1'b0;
  logic [9:0]        bird_y = '0;
  pipe_x_t [3:0]     pipe_x;
  gap_y_t  [3:0]     pipe_gap_y;
  logic              scene_valid = 1'b0;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              hs_o;
  logic              vs_o;
  logic              de_o;
  logic              frame_start;
  logic              collision;

  int checks = 0;
  int errors = 0;
  int serial = 0;
  logic [26:0] exp_q[$];
  int          id_q[$];
  logic        chk_now = 1'b0;
  logic        chk_d1 = 1'b0;
  logic        chk_d2 = 1'b0;
  logic [26:0] mon_e;
  int          mon_s;

  vec_t   vt[$];
  scene_t sc[3];

  scene_renderer dut (
    .clk_rgb     (clk_rgb),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .bird_y      (bird_y),
    .pipe_x      (pipe_x),
    .pipe_gap_y  (pipe_gap_y),
    .scene_valid (scene_valid),
    .r           (r),
    .g           (g),
    .b           (b),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .de_o        (de_o),
    .frame_start (frame_start),
    .collision   (collision)
  );

  // Clock
  always #5 clk_rgb = ~clk_rgb;

  // Scoreboard: an entry pushed with a driven pixel is due two edges later.
  always @(posedge clk_rgb) begin
    chk_d1 <= chk_now;
    chk_d2 <= chk_d1;
  end

  always @(negedge clk_rgb) begin
    if (chk_d2) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_queue_empty: got %h with no expected entry", {r, g, b, hs_o, vs_o, de_o});
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = id_q.pop_front();
        if ({r, g, b, hs_o, vs_o, de_o} !== mon_e) begin
          errors++;
          $display("FAIL pixel#%0d: got rgb=%h hs/vs/de=%b expected rgb=%h hs/vs/de=%b",
                   mon_s, {r, g, b}, {hs_o, vs_o, de_o}, mon_e[26:3], mon_e[2:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic drive(input int xi, input int yi, input logic hsi, input logic vsi,
                       input logic dei, input logic chk, input logic [23:0] rgb);
    x = 11'(xi);
    y = 10'(yi);
    hs = hsi;
    vs = vsi;
    de = dei;
    chk_now = chk;
    if (chk) begin
      exp_q.push_back({dei ? rgb : 24'h000000, hsi, vsi, dei});
      id_q.push_back(serial);
      serial++;
    end
  endtask

  task automatic step(input int xi, input int yi, input logic hsi, input logic vsi,
                      input logic dei, input logic chk, input logic [23:0] rgb);
    drive(xi, yi, hsi, vsi, dei, chk, rgb);
    @(posedge clk_rgb);
    #1;
  endtask

  task automatic pix(input int xi, input int yi, input logic [23:0] rgb);
    step(xi, yi, 1'b0, 1'b0, 1'b1, 1'b1, rgb);
  endtask

  task automatic vs_rise();
    drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0);
    #1;
    check("frame_start_pulse", 32'(frame_start), 32'd1);
    @(posedge clk_rgb);
    #1;
    drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0);
    #1;
    check("frame_start_one_cycle", 32'(frame_start), 32'd0);
    @(posedge clk_rgb);
    #1;
  endtask

  task automatic new_frame();
    step(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0);
    vs_rise();
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
  endtask

  task automatic set_scene(input int bird, input int px0, input int g0,
                           input int px1, input int g1);
    bird_y        = 10'(bird);
    pipe_x[0]     = pipe_x_t'(px0);
    pipe_gap_y[0] = gap_y_t'(g0);
    pipe_x[1]     = pipe_x_t'(px1);
    pipe_gap_y[1] = gap_y_t'(g1);
    pipe_x[2]     = pipe_x_t'(1280);
    pipe_gap_y[2] = gap_y_t'(264);
    pipe_x[3]     = pipe_x_t'(1280);
    pipe_gap_y[3] = gap_y_t'(264);
    scene_valid   = 1'b1;
  endtask

  function automatic void add(input int s, input int xi, input int yi,
                              input logic hsi, input logic dei, input logic [23:0] rgb);
    vec_t v;
    v.s = s; v.x = xi; v.y = yi; v.hs = hsi; v.de = dei; v.rgb = rgb;
    vt.push_back(v);
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      pipe_x[i]     = '0;
      pipe_gap_y[i] = '0;
    end

    sc[0] = '{360, 1280, 264, 1280, 264};
    sc[1] = '{100, 300, 200, 1280, 264};
    sc[2] = '{100, -50, 200, 1250, 200};

    // Scene 0: reset shadows (bird at 360, all pipes off-screen)
    add(0, 0, 0, 1'b1, 1'b1, SKY);
    add(0, 210, 370, 1'b0, 1'b1, BIRD);
    add(0, 210, 392, 1'b0, 1'b1, SKY);
    add(0, 1279, 0, 1'b1, 1'b1, SKY);
    add(0, 5, 656, 1'b0, 1'b1, GROUND);
    add(0, 5, 655, 1'b0, 1'b1, SKY);
    add(0, 0, 0, 1'b0, 1'b0, 24'h0);
    // Scene 1: bird 100, pipe 0 at 300 with gap 200..391
    add(1, 210, 110, 1'b0, 1'b1, BIRD);
    add(1, 310, 50, 1'b0, 1'b1, PIPE);
    add(1, 310, 300, 1'b0, 1'b1, SKY);
    add(1, 5, 700, 1'b0, 1'b1, GROUND);
    add(1, 300, 199, 1'b0, 1'b1, PIPE);
    add(1, 299, 50, 1'b0, 1'b1, SKY);
    add(1, 395, 50, 1'b0, 1'b1, PIPE);
    add(1, 396, 50, 1'b0, 1'b1, SKY);
    add(1, 310, 200, 1'b0, 1'b1, SKY);
    add(1, 310, 391, 1'b0, 1'b1, SKY);
    add(1, 310, 392, 1'b0, 1'b1, PIPE);
    add(1, 310, 660, 1'b1, 1'b1, PIPE);
    add(1, 200, 100, 1'b0, 1'b1, BIRD);
    add(1, 231, 131, 1'b0, 1'b1, BIRD);
    add(1, 232, 110, 1'b0, 1'b1, SKY);
    add(1, 199, 110, 1'b0, 1'b1, SKY);
    add(1, 210, 132, 1'b0, 1'b1, SKY);
    add(1, 210, 99, 1'b0, 1'b1, SKY);
    add(1, 210, 110, 1'b1, 1'b0, 24'h0);
    // Scene 2: pipes clipped at the left and right screen edges
    add(2, 0, 50, 1'b0, 1'b1, PIPE);
    add(2, 45, 50, 1'b0, 1'b1, PIPE);
    add(2, 46, 50, 1'b0, 1'b1, SKY);
    add(2, 0, 300, 1'b0, 1'b1, SKY);
    add(2, 1249, 50, 1'b0, 1'b1, SKY);
    add(2, 1250, 50, 1'b0, 1'b1, PIPE);
    add(2, 1279, 50, 1'b0, 1'b1, PIPE);
    add(2, 1279, 300, 1'b0, 1'b1, SKY);
    add(2, 1279, 700, 1'b0, 1'b1, PIPE);
    add(2, 210, 110, 1'b0, 1'b1, BIRD);

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk_rgb);
    #1;
    check("reset_rgb", 32'({r, g, b}), 32'd0);
    check("reset_syncs", 32'({hs_o, vs_o, de_o}), 32'd0);
    check("reset_frame_start", 32'(frame_start), 32'd0);
    check("reset_collision", 32'(collision), 32'd0);
    rst_n = 1'b1;

    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin
        set_scene(sc[s].bird, sc[s].px0, sc[s].g0, sc[s].px1, sc[s].g1);
        new_frame();
      end
      foreach (vt[i]) begin
        if (vt[i].s == s) step(vt[i].x, vt[i].y, vt[i].hs, 1'b0, vt[i].de, 1'b1, vt[i].rgb);
      end
    end

    // Mid-frame change is invisible until the next boundary; invalid scene is ignored
    bird_y = 10'd300;
    pix(210, 110, BIRD);
    pix(210, 310, SKY);
    new_frame();
    pix(210, 310, BIRD);
    pix(210, 110, SKY);
    bird_y = 10'd500;
    scene_valid = 1'b0;
    new_frame();
    pix(210, 310, BIRD);
    pix(210, 510, SKY);

    // Collision with the ground
    set_scene(640, 1280, 264, 1280, 264);
    new_frame();
    check("collision_clean_start", 32'(collision), 32'd0);
    pix(210, 660, BIRD);
    pix(210, 700, GROUND);
    new_frame();
    check("collision_ground", 32'(collision), 32'd1);
    pix(210, 645, BIRD);
    step(210, 660, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    new_frame();
    check("collision_clear", 32'(collision), 32'd0);
    // Hit on the boundary cycle is carried into the new frame
    pix(210, 660, BIRD);
    vs_rise();
    check("collision_edge_old", 32'(collision), 32'd0);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    pix(5, 0, SKY);
    new_frame();
    check("collision_edge_carry", 32'(collision), 32'd1);

    // Bird over pipe priority and pipe collision
    set_scene(640, 190, 0, 1280, 264);
    new_frame();
    check("collision_before_pipe", 32'(collision), 32'd0);
    pix(210, 645, BIRD);
    pix(250, 645, PIPE);
    pix(250, 100, SKY);
    pix(189, 300, SKY);
    pix(190, 300, PIPE);
    pix(250, 700, PIPE);
    new_frame();
    check("collision_pipe", 32'(collision), 32'd1);

    // One-cycle reset mid-line
    step(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, SKY);
    step(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, SKY);
    drive(211, 645, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
    rst_n = 1'b0;
    @(posedge clk_rgb);
    #1;
    check("midreset_rgb", 32'({r, g, b}), 32'd0);
    check("midreset_syncs", 32'({hs_o, vs_o, de_o}), 32'd0);
    check("midreset_frame_start", 32'(frame_start), 32'd0);
    check("midreset_collision", 32'(collision), 32'd0);
    rst_n = 1'b1;
    drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, SKY);
    #1;
    check("no_false_edge", 32'(frame_start), 32'd0);
    @(posedge clk_rgb);
    #1;
    pix(210, 370, BIRD);
    pix(210, 660, GROUND);
    pix(250, 645, SKY);
    new_frame();
    check("collision_after_reset", 32'(collision), 32'd0);

    repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
